// File: rtl/gpio_in_conditioner_pkg.sv
// rtl/gpio_in_conditioner_pkg.sv - shared defaults and helpers for the GPIO input conditioner
package gpio_in_conditioner_pkg;

    // Defaults shared by the conditioner, the GPIO peripheral and the top level.
    localparam int GPIO_WIDTH           = 32;
    localparam int GPIO_SYNC_STAGES     = 2;
    localparam int GPIO_DEBOUNCE_CYCLES = 50000;
    localparam int GPIO_CNT_W           = 16;

    // Terminal count of the debounce counter: a differing level is accepted
    // on the edge where the counter already holds this value.
    function automatic int cnt_limit(input int debounce_cycles);
        return debounce_cycles - 1;
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - synchroniser, debounce counter and edge pulses for one input bit
//
// Ports:
//   clk_i     clock, all state on posedge
//   rst_i     asynchronous active-low reset
//   pin_i     raw asynchronous pin
//   bypass_i  1 = accept a differing synchronised level on the first edge
//   level_o   debounced stable level (registered)
//   rise_o    one-cycle pulse when level_o goes 0->1 (registered)
//   fall_o    one-cycle pulse when level_o goes 1->0 (registered)
//   upd_o     combinational: level_o updates on the coming edge
module gpio_debounce_bit
    import gpio_in_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES,
    parameter int CNT_W           = GPIO_CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    input  logic bypass_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic upd_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(cnt_limit(DEBOUNCE_CYCLES));

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;
    logic                   accept;

    assign s = sync_q[SYNC_STAGES-1];

    // A differing level is taken once it has been seen for DEBOUNCE_CYCLES
    // consecutive edges, or immediately in bypass. Any match restarts the run,
    // so the counter can never pass LIMIT.
    assign accept = (s != level_q) && (bypass_i || (cnt_q == LIMIT));

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (accept) begin
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
        end else if (s != level_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign upd_o   = accept;

endmodule

// File: rtl/gpio_in_conditioner.sv
// rtl/gpio_in_conditioner.sv - per-bit synchronise/debounce of raw pins with edge pulses and event flag
//
// Ports:
//   clk_i     clock, all state on posedge
//   rst_i     asynchronous active-low reset
//   pins_i    raw asynchronous pins [WIDTH]
//   bypass_i  1 = no debounce, synchroniser still in path
//   gpio_bi   debounced stable levels [WIDTH], feeds the GPIO read data
//   rise_o    per-bit one-cycle 0->1 pulses [WIDTH]
//   fall_o    per-bit one-cycle 1->0 pulses [WIDTH]
//   event_o   OR of all pulses, aligned with them
module gpio_in_conditioner
    import gpio_in_conditioner_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH,
    parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES,
    parameter int CNT_W           = GPIO_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] pins_i,
    input  logic             bypass_i,
    output logic [WIDTH-1:0] gpio_bi,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             event_o
);

    logic [WIDTH-1:0] upd;
    logic             event_q, event_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .pin_i    (pins_i[i]),
            .bypass_i (bypass_i),
            .level_o  (gpio_bi[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i]),
            .upd_o    (upd[i])
        );
    end

    // Every accepted update yields exactly one rise or fall pulse, so ORing the
    // pre-register update strobes lands event_o in the same cycle as the pulses.
    assign event_d = |upd;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            event_q <= 1'b0;
        end else begin
            event_q <= event_d;
        end
    end

    assign event_o = event_q;

endmodule
